// File: rtl/div_pkg.sv
// Shared state encoding, handshake levels and sign helpers for the sequential divider.
// Latency: none (types, constants and pure functions only).
// Backpressure: none.
package div_pkg;

  // State encodings, kept as named constants so other blocks can decode them.
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIter  = 2'd1;
  localparam logic [1:0] StFixup = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = StIdle,
    ITER  = StIter,
    FIXUP = StFixup,
    DONE  = StDone
  } div_state_e;

  // Levels of the start_i request line.
  localparam logic DivStart = 1'b1;
  localparam logic DivStop  = 1'b0;

  // Helpers work on a wide container; callers extend their operand into it
  // (sign-extended for abs_w) and keep only the low WIDTH bits of the result.
  localparam int DivMaxW = 128;

  // Two's-complement negation.
  function automatic logic [DivMaxW-1:0] neg_w(input logic [DivMaxW-1:0] value);
    return ~value + {{(DivMaxW-1){1'b0}}, 1'b1};
  endfunction

  // Magnitude of a sign-extended value; unsigned values pass through untouched.
  function automatic logic [DivMaxW-1:0] abs_w(input logic [DivMaxW-1:0] value,
                                               input logic is_signed);
    return (is_signed && value[DivMaxW-1]) ? neg_w(value) : value;
  endfunction

endpackage

// File: rtl/param_seq_divider_if.sv
// Pipeline-side request/response bundle of the sequential divider.
// Latency: none (wires only).
// Backpressure: level start held by the master until it has consumed the result.
interface param_seq_divider_if #(
  parameter int WIDTH = 32
) ();
  logic             start_i;
  logic             annul_i;
  logic             signed_i;
  logic [WIDTH-1:0] dividend_i;
  logic [WIDTH-1:0] divisor_i;
  logic             busy_o;
  logic             ready_o;
  logic [WIDTH-1:0] quotient_o;
  logic [WIDTH-1:0] remainder_o;
  logic             div_zero_o;
  logic             overflow_o;

  modport master (
    output start_i, annul_i, signed_i, dividend_i, divisor_i,
    input  busy_o, ready_o, quotient_o, remainder_o, div_zero_o, overflow_o
  );

  modport slave (
    input  start_i, annul_i, signed_i, dividend_i, divisor_i,
    output busy_o, ready_o, quotient_o, remainder_o, div_zero_o, overflow_o
  );
endinterface

// File: rtl/div_lzc.sv
// Leading-zero counter over a WIDTH-bit value; an all-zero value counts WIDTH.
// Latency: combinational.
// Backpressure: none.
module div_lzc #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]               value,
  output logic [$clog2(WIDTH+1)-1:0]     count
);
  localparam int CntW = $clog2(WIDTH + 1);

  logic found;

  // Scan from the MSB and count zeros until the first set bit.
  always_comb begin
    count = '0;
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found && !value[i]) count = count + CntW'(1);
      found = found | value[i];
    end
  end
endmodule

// File: rtl/param_seq_divider.sv
// Multi-cycle restoring divider, BITS_PER_CYCLE quotient bits per iteration, optional leading-zero skip.
// Latency: N+1 edges from accept to ready_o (N = iterations); divide-by-zero and MIN/-1 are ready at accept.
// Backpressure: result held in DONE while start_i stays high; annul_i aborts ITER/FIXUP.
module param_seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int EARLY_TERM     = 0
) (
  input logic               clk,
  input logic               rst,
  param_seq_divider_if.slave dif
);

  localparam int NMax = WIDTH / BITS_PER_CYCLE;
  localparam int CntW = $clog2(NMax + 1);
  localparam int LzW  = $clog2(WIDTH + 1);
  localparam int ExtW = DivMaxW - WIDTH;
  localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       state_q, state_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic             dz_q, dz_d;
  logic             ov_q, ov_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_out_q, rem_out_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] part_q, part_d;     // partial remainder
  logic [WIDTH-1:0] dq_q, dq_d;         // dividend bits shift out the top, quotient bits in the bottom
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;

  // Operand magnitudes for the accept cycle.
  logic [DivMaxW-1:0] dvd_abs_ext, dvs_abs_ext;
  logic [WIDTH-1:0]   dvd_abs, dvs_abs;
  assign dvd_abs_ext = abs_w({{ExtW{dif.dividend_i[WIDTH-1]}}, dif.dividend_i}, dif.signed_i);
  assign dvs_abs_ext = abs_w({{ExtW{dif.divisor_i[WIDTH-1]}}, dif.divisor_i}, dif.signed_i);
  assign dvd_abs = dvd_abs_ext[WIDTH-1:0];
  assign dvs_abs = dvs_abs_ext[WIDTH-1:0];

  // Sign fixup candidates for the final result.
  logic [DivMaxW-1:0] quo_neg_ext, rem_neg_ext;
  assign quo_neg_ext = neg_w({{ExtW{1'b0}}, dq_q});
  assign rem_neg_ext = neg_w({{ExtW{1'b0}}, part_q});

  logic unused_ext;
  assign unused_ext = ^{dvd_abs_ext[DivMaxW-1:WIDTH], dvs_abs_ext[DivMaxW-1:WIDTH],
                        quo_neg_ext[DivMaxW-1:WIDTH], rem_neg_ext[DivMaxW-1:WIDTH]};

  // Leading zeros of |dividend| only matter when iterations may be skipped.
  logic [LzW-1:0] lz;
  if (EARLY_TERM != 0) begin : g_lzc
    div_lzc #(.WIDTH(WIDTH)) u_lzc (.value(dvd_abs), .count(lz));
  end else begin : g_no_lzc
    assign lz = '0;
  end

  // Skip whole iterations only: the pre-shift is lz rounded down to the step size.
  logic [31:0]      lz_w, shift_amt, iter_n;
  logic [WIDTH-1:0] dvd_shifted;
  assign lz_w        = 32'(lz);
  assign shift_amt   = (lz_w / BITS_PER_CYCLE) * BITS_PER_CYCLE;
  assign iter_n      = (32'(WIDTH) - shift_amt) / 32'(BITS_PER_CYCLE);
  assign dvd_shifted = dvd_abs << shift_amt;

  // Chained restoring steps; each block consumes one dividend bit and yields one quotient bit.
  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
    logic [WIDTH-1:0] rem_in, dq_in, rem_out, dq_out;
    logic [WIDTH:0]   shifted, trial;
    if (g == 0) begin : g_first
      assign rem_in = part_q;
      assign dq_in  = dq_q;
    end else begin : g_next
      assign rem_in = g_step[g-1].rem_out;
      assign dq_in  = g_step[g-1].dq_out;
    end
    assign shifted = {rem_in, dq_in[WIDTH-1]};
    // The partial remainder is below the divisor, so the MSB of this difference is its sign.
    assign trial   = shifted - {1'b0, divisor_q};
    assign rem_out = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign dq_out  = {dq_in[WIDTH-2:0], ~trial[WIDTH]};
  end

  logic [WIDTH-1:0] step_rem, step_dq;
  assign step_rem = g_step[BITS_PER_CYCLE-1].rem_out;
  assign step_dq  = g_step[BITS_PER_CYCLE-1].dq_out;

  // Next-state and next-output decisions for the accept/iterate/fixup/hold sequence.
  always_comb begin
    state_d   = state_q;
    busy_d    = 1'b0;
    ready_d   = ready_q;
    dz_d      = dz_q;
    ov_d      = ov_q;
    quo_d     = quo_q;
    rem_out_d = rem_out_q;
    divisor_d = divisor_q;
    part_d    = part_q;
    dq_d      = dq_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;

    unique case (state_q)
      IDLE: begin
        if ((dif.start_i == DivStart) && !dif.annul_i) begin
          neg_quo_d = dif.signed_i & (dif.dividend_i[WIDTH-1] ^ dif.divisor_i[WIDTH-1]);
          neg_rem_d = dif.signed_i & dif.dividend_i[WIDTH-1];
          divisor_d = dvs_abs;
          part_d    = '0;
          dq_d      = dvd_shifted;
          cnt_d     = CntW'(iter_n);
          if (dif.divisor_i == '0) begin
            state_d   = DONE;
            quo_d     = '1;
            rem_out_d = dif.dividend_i;
            dz_d      = 1'b1;
            ready_d   = 1'b1;
          end else if (dif.signed_i && (dif.dividend_i == MinVal) && (dif.divisor_i == '1)) begin
            state_d   = DONE;
            quo_d     = MinVal;
            rem_out_d = '0;
            ov_d      = 1'b1;
            ready_d   = 1'b1;
          end else if (iter_n == 32'd0) begin
            state_d = FIXUP;
          end else begin
            state_d = ITER;
          end
        end
      end
      ITER: begin
        if (dif.annul_i) begin
          state_d = IDLE;
        end else begin
          part_d = step_rem;
          dq_d   = step_dq;
          cnt_d  = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) state_d = FIXUP;
        end
      end
      FIXUP: begin
        if (dif.annul_i) begin
          state_d = IDLE;
        end else begin
          quo_d     = neg_quo_q ? quo_neg_ext[WIDTH-1:0] : dq_q;
          rem_out_d = neg_rem_q ? rem_neg_ext[WIDTH-1:0] : part_q;
          ready_d   = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (dif.start_i == DivStop) begin
          state_d   = IDLE;
          ready_d   = 1'b0;
          dz_d      = 1'b0;
          ov_d      = 1'b0;
          quo_d     = '0;
          rem_out_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == ITER) || (state_d == FIXUP);
  end

  // State, datapath and registered outputs; synchronous reset drops any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
      dz_q      <= 1'b0;
      ov_q      <= 1'b0;
      quo_q     <= '0;
      rem_out_q <= '0;
      divisor_q <= '0;
      part_q    <= '0;
      dq_q      <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
      dz_q      <= dz_d;
      ov_q      <= ov_d;
      quo_q     <= quo_d;
      rem_out_q <= rem_out_d;
      divisor_q <= divisor_d;
      part_q    <= part_d;
      dq_q      <= dq_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  assign dif.busy_o      = busy_q;
  assign dif.ready_o     = ready_q;
  assign dif.quotient_o  = quo_q;
  assign dif.remainder_o = rem_out_q;
  assign dif.div_zero_o  = dz_q;
  assign dif.overflow_o  = ov_q;

endmodule

// File: tb/tb_param_seq_divider.sv
// Bench for three divider configurations: 32b radix-2, 32b with early termination, 16b two bits per cycle.
// Latency: checks ready_o timing per operation against an arithmetic latency model.
// Backpressure: holds start_i in DONE, annuls mid-iteration and resets mid-iteration.
module tb_param_seq_divider;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  param_seq_divider_if #(.WIDTH(32)) if_a ();
  param_seq_divider_if #(.WIDTH(32)) if_e ();
  param_seq_divider_if #(.WIDTH(16)) if_h ();

  param_seq_divider #(.WIDTH(32), .BITS_PER_CYCLE(1), .EARLY_TERM(0)) u_a (.clk(clk), .rst(rst), .dif(if_a.slave));
  param_seq_divider #(.WIDTH(32), .BITS_PER_CYCLE(1), .EARLY_TERM(1)) u_e (.clk(clk), .rst(rst), .dif(if_e.slave));
  param_seq_divider #(.WIDTH(16), .BITS_PER_CYCLE(2), .EARLY_TERM(0)) u_h (.clk(clk), .rst(rst), .dif(if_h.slave));

  int cfg_w [3] = '{32, 32, 16};
  int cfg_b [3] = '{1, 1, 2};
  int cfg_et[3] = '{0, 1, 0};

  logic        drv_start[3], drv_annul[3], drv_sgn[3];
  logic [31:0] drv_a[3], drv_b[3];
  logic        o_rdy[3], o_busy[3], o_dz[3], o_ov[3];
  logic [31:0] o_q[3], o_r[3];

  assign if_a.start_i = drv_start[0]; assign if_a.annul_i = drv_annul[0]; assign if_a.signed_i = drv_sgn[0];
  assign if_a.dividend_i = drv_a[0];  assign if_a.divisor_i = drv_b[0];
  assign if_e.start_i = drv_start[1]; assign if_e.annul_i = drv_annul[1]; assign if_e.signed_i = drv_sgn[1];
  assign if_e.dividend_i = drv_a[1];  assign if_e.divisor_i = drv_b[1];
  assign if_h.start_i = drv_start[2]; assign if_h.annul_i = drv_annul[2]; assign if_h.signed_i = drv_sgn[2];
  assign if_h.dividend_i = drv_a[2][15:0]; assign if_h.divisor_i = drv_b[2][15:0];

  assign o_rdy[0] = if_a.ready_o; assign o_busy[0] = if_a.busy_o; assign o_dz[0] = if_a.div_zero_o;
  assign o_ov[0] = if_a.overflow_o; assign o_q[0] = if_a.quotient_o; assign o_r[0] = if_a.remainder_o;
  assign o_rdy[1] = if_e.ready_o; assign o_busy[1] = if_e.busy_o; assign o_dz[1] = if_e.div_zero_o;
  assign o_ov[1] = if_e.overflow_o; assign o_q[1] = if_e.quotient_o; assign o_r[1] = if_e.remainder_o;
  assign o_rdy[2] = if_h.ready_o; assign o_busy[2] = if_h.busy_o; assign o_dz[2] = if_h.div_zero_o;
  assign o_ov[2] = if_h.overflow_o; assign o_q[2] = {16'h0, if_h.quotient_o}; assign o_r[2] = {16'h0, if_h.remainder_o};

  // Model state: expected result of the operation in flight and when it should appear.
  bit          run[3] = '{1'b0, 1'b0, 1'b0};
  int          acc_edge[3], lat[3];
  logic [31:0] exp_q[3], exp_r[3];
  bit          exp_dz[3], exp_ov[3];
  int          ecnt = 0;
  bit          chk_en = 1'b0;
  int          n_chk = 0, n_pass = 0;

  // Values captured at the moment ready_o was seen.
  int          g_lat;
  logic [31:0] g_q, g_r;
  logic        g_dz, g_ov;

  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d: got %h expected %h (t=%0t)", name, d, act, exp, $time);
  endtask

  // Reference division from plain integer arithmetic.
  function automatic void ref_div(input int w, input bit sgn, input logic [31:0] a_in, input logic [31:0] b_in,
                                  output logic [31:0] q, output logic [31:0] r, output bit dz, output bit ov,
                                  output logic [31:0] mag);
    longint sa, sb, half, lq, lr, m;
    logic [31:0] mask, a, b;
    mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    a = a_in & mask;
    b = b_in & mask;
    half = 1;
    half = half << (w - 1);
    sa = {32'h0, a};
    sb = {32'h0, b};
    if (sgn && sa >= half) sa = sa - 2 * half;
    if (sgn && sb >= half) sb = sb - 2 * half;
    m = (sa < 0) ? -sa : sa;
    mag = m[31:0];
    dz = 1'b0; ov = 1'b0;
    if (b == 32'h0) begin
      dz = 1'b1; q = mask; r = a;
    end else if (sgn && sa == -half && sb == -1) begin
      ov = 1'b1; q = a; r = 32'h0;
    end else begin
      lq = sa / sb;
      lr = sa % sb;
      q = lq[31:0] & mask;
      r = lr[31:0] & mask;
    end
  endfunction

  function automatic int lat_of(input int d, input logic [31:0] mag, input bit dz, input bit ov);
    int lz, n;
    if (dz || ov) return 0;
    n = cfg_w[d] / cfg_b[d];
    if (cfg_et[d] != 0) begin
      lz = 0;
      for (int i = cfg_w[d] - 1; i >= 0; i--) begin
        if (mag[i]) break;
        lz++;
      end
      n = (cfg_w[d] - lz + cfg_b[d] - 1) / cfg_b[d];
    end
    return n + 1;
  endfunction

  // Every cycle: ready/busy timing and output values against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 3; d++) begin
        int k;
        bit er, eb;
        er = 1'b0; eb = 1'b0;
        if (run[d]) begin
          k  = ecnt - acc_edge[d];
          er = (k >= lat[d]);
          eb = (k < lat[d]);
        end
        chk("ready", d, {31'b0, o_rdy[d]}, {31'b0, er});
        chk("busy", d, {31'b0, o_busy[d]}, {31'b0, eb});
        chk("quotient", d, o_q[d], er ? exp_q[d] : 32'h0);
        chk("remainder", d, o_r[d], er ? exp_r[d] : 32'h0);
        chk("div_zero", d, {31'b0, o_dz[d]}, {31'b0, er & exp_dz[d]});
        chk("overflow", d, {31'b0, o_ov[d]}, {31'b0, er & exp_ov[d]});
      end
    end
  end

  // Raise start with fresh operands and arm the model; returns just before edge E0.
  task automatic arm(input int d, input bit sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r, mag;
    bit dz, ov;
    ref_div(cfg_w[d], sgn, a, b, q, r, dz, ov, mag);
    @(negedge clk); #1;
    drv_sgn[d] = sgn; drv_a[d] = a; drv_b[d] = b; drv_start[d] = 1'b1;
    exp_q[d] = q; exp_r[d] = r; exp_dz[d] = dz; exp_ov[d] = ov;
    lat[d] = lat_of(d, mag, dz, ov);
    acc_edge[d] = ecnt + 1;
    run[d] = 1'b1;
  endtask

  task automatic do_op(input int d, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                       input int hold, input bit annul_in_done);
    arm(d, sgn, a, b);
    @(posedge clk); #1;
    // Operands must be ignored once accepted.
    drv_a[d] = ~a; drv_b[d] = b ^ 32'h5; drv_sgn[d] = ~sgn;
    g_lat = -1;
    for (int i = 0; i < 60; i++) begin
      if (o_rdy[d]) begin
        g_lat = ecnt - acc_edge[d];
        break;
      end
      @(posedge clk); #1;
    end
    g_q = o_q[d]; g_r = o_r[d]; g_dz = o_dz[d]; g_ov = o_ov[d];
    chk("latency", d, g_lat, lat[d]);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk); #1;
      drv_annul[d] = annul_in_done && (i == 0);
    end
    @(negedge clk); #1;
    drv_annul[d] = 1'b0; drv_start[d] = 1'b0; run[d] = 1'b0;
  endtask

  task automatic lit(input string name, input int d, input logic [31:0] q, input logic [31:0] r,
                     input bit dz, input bit ov, input int l);
    chk({name, "_q"}, d, g_q, q);
    chk({name, "_r"}, d, g_r, r);
    chk({name, "_flags"}, d, {30'b0, g_dz, g_ov}, {30'b0, dz, ov});
    chk({name, "_lat"}, d, g_lat, l);
  endtask

  initial begin
    logic [31:0] ra, rb;
    bit rs;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      drv_start[d] = 1'b0; drv_annul[d] = 1'b0; drv_sgn[d] = 1'b0; drv_a[d] = 32'h0; drv_b[d] = 32'h0;
    end
    @(posedge clk); #1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b0;

    // 32-bit, one bit per cycle.
    do_op(0, 1'b0, 32'd100, 32'd7, 0, 1'b0);        lit("u100_7", 0, 32'd14, 32'd2, 0, 0, 33);
    do_op(0, 1'b1, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);  lit("sm7_2", 0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, 0, 33);
    do_op(0, 1'b1, 32'd7, 32'hFFFF_FFFE, 0, 1'b0);  lit("s7_m2", 0, 32'hFFFF_FFFD, 32'd1, 0, 0, 33);
    do_op(0, 1'b0, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);  lit("ubig_2", 0, 32'h7FFF_FFFC, 32'd1, 0, 0, 33);
    do_op(0, 1'b0, 32'd5, 32'd0, 0, 1'b0);          lit("div0", 0, 32'hFFFF_FFFF, 32'd5, 1, 0, 0);
    do_op(0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0); lit("ovf", 0, 32'h8000_0000, 32'd0, 0, 1, 0);

    // Annul at iteration cycle 10, then a clean operation held in DONE (with an ignored annul).
    arm(0, 1'b0, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    @(negedge clk); #1;
    drv_start[0] = 1'b0; drv_annul[0] = 1'b1; run[0] = 1'b0;
    @(negedge clk); #1;
    drv_annul[0] = 1'b0;
    chk("annul_ready", 0, {31'b0, o_rdy[0]}, 32'd0);
    chk("annul_busy", 0, {31'b0, o_busy[0]}, 32'd0);
    do_op(0, 1'b0, 32'd9, 32'd3, 5, 1'b1);          lit("u9_3", 0, 32'd3, 32'd0, 0, 0, 33);
    chk("release_q", 0, o_q[0], 32'd3);             // still before the release edge
    @(negedge clk); #1;
    chk("released_q", 0, o_q[0], 32'd0);
    chk("released_ready", 0, {31'b0, o_rdy[0]}, 32'd0);

    // start together with annul in IDLE must not accept.
    @(negedge clk); #1;
    drv_a[0] = 32'd8; drv_b[0] = 32'd2; drv_start[0] = 1'b1; drv_annul[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("annul_idle_busy", 0, {31'b0, o_busy[0]}, 32'd0);
    #1;
    drv_start[0] = 1'b0; drv_annul[0] = 1'b0;

    // Early termination.
    do_op(1, 1'b0, 32'h0000_000F, 32'd3, 0, 1'b0);  lit("et15_3", 1, 32'd5, 32'd0, 0, 0, 5);
    do_op(1, 1'b0, 32'd0, 32'd9, 0, 1'b0);          lit("et0_9", 1, 32'd0, 32'd0, 0, 0, 1);
    do_op(1, 1'b1, 32'hFFFF_FFF1, 32'd3, 0, 1'b0);  lit("etm15_3", 1, 32'hFFFF_FFFB, 32'd0, 0, 0, 5);
    do_op(1, 1'b0, 32'h8000_0000, 32'd3, 0, 1'b0);  lit("etbig_3", 1, 32'h2AAA_AAAA, 32'd2, 0, 0, 33);

    // 16-bit, two bits per cycle.
    do_op(2, 1'b0, 32'd1000, 32'd7, 0, 1'b0);       lit("h1000_7", 2, 32'd142, 32'd6, 0, 0, 9);
    do_op(2, 1'b1, 32'h0000_FC18, 32'd7, 0, 1'b0);  lit("hm1000_7", 2, 32'h0000_FF72, 32'h0000_FFFA, 0, 0, 9);

    // Reset in the middle of iteration.
    arm(2, 1'b0, 32'd1000, 32'd7);
    repeat (4) @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b1; drv_start[2] = 1'b0; run[2] = 1'b0;
    @(negedge clk); #1;
    rst = 1'b0;
    chk("rst_busy", 2, {31'b0, o_busy[2]}, 32'd0);
    chk("rst_q", 2, o_q[2], 32'd0);
    do_op(2, 1'b0, 32'd1000, 32'd7, 0, 1'b0);       lit("h_after_rst", 2, 32'd142, 32'd6, 0, 0, 9);

    // Random pairs, checked cycle by cycle against the model.
    for (int i = 0; i < 1000; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom & 32'h0000_FFFF;
      rb = $urandom & 32'h0000_FFFF;
      if ($urandom_range(0, 40) == 0) rb = 32'h0;
      if ($urandom_range(0, 40) == 0) begin rs = 1'b1; ra = 32'h8000; rb = 32'hFFFF; end
      do_op(2, rs, ra, rb, 0, 1'b0);
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
